// File: rtl/bram_logger_pkg.sv
// bram_logger_pkg: shared types, width helpers and entry packing for bram_logger_mc
package bram_logger_pkg;

    typedef enum logic [1:0] {READY, CLEARING, FULL} state_t;

    localparam int MAX_BITW = 512;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int chan_bitw(input int n);
        return clog2(n) > 1 ? clog2(n) : 1;
    endfunction

    // Entry width rounded up to whole 32-bit words so the bus bridge reads full words.
    function automatic int entry_bitw(input int ts_bitw, input int ch_bitw, input int data_bitw);
        return ((ts_bitw + ch_bitw + data_bitw + 31) / 32) * 32;
    endfunction

    // Layout LSB first: timestamp, channel id, payload; caller truncates to its entry width.
    function automatic logic [MAX_BITW-1:0] pack_entry(
        input logic [MAX_BITW-1:0] ts,
        input logic [MAX_BITW-1:0] chan,
        input logic [MAX_BITW-1:0] data,
        input int ts_bitw,
        input int ch_bitw
    );
        return (data << (ts_bitw + ch_bitw)) | (chan << ts_bitw) | ts;
    endfunction

endpackage

// File: rtl/bram_logger_mc_if.sv
// bram_logger_mc_if: event sources and read port of the logger
// LogData_DI/LogTrigger_SI/ChanEn_SI: per-channel payload, strobe, enable
// RdEn_SI/RdAddr_DI/RdData_DO: 1-cycle-latency read port
interface bram_logger_mc_if #(
    parameter int NUM_CHANNELS  = 4,
    parameter int LOG_DATA_BITW = 32,
    parameter int ADDR_BITW     = 10,
    parameter int ENTRY_BITW    = 96
);
    logic [NUM_CHANNELS*LOG_DATA_BITW-1:0] LogData_DI;
    logic [NUM_CHANNELS-1:0]               LogTrigger_SI;
    logic [NUM_CHANNELS-1:0]               ChanEn_SI;
    logic                                  RdEn_SI;
    logic [ADDR_BITW-1:0]                  RdAddr_DI;
    logic [ENTRY_BITW-1:0]                 RdData_DO;

    modport master (output LogData_DI, LogTrigger_SI, ChanEn_SI, RdEn_SI, RdAddr_DI, input RdData_DO);
    modport slave (input LogData_DI, LogTrigger_SI, ChanEn_SI, RdEn_SI, RdAddr_DI, output RdData_DO);
endinterface

// File: rtl/bram_logger_mc_sdp_bram_array.sv
// sdp_bram_array: simple dual-port RAM, one write port and one registered read port
// Clk_CI/Rst_RI: clock, async reset of the read register only
// WrEn_SI/WrAddr_DI/WrData_DI: write port; RdEn_SI/RdAddr_DI/RdData_DO: read port, old data on collision
module sdp_bram_array
    import bram_logger_pkg::*;
#(
    parameter int DATA_BITW   = 32,
    parameter int NUM_ENTRIES = 1024,
    localparam int ADDR_BITW  = clog2(NUM_ENTRIES)
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic                 WrEn_SI,
    input  logic [ADDR_BITW-1:0] WrAddr_DI,
    input  logic [DATA_BITW-1:0] WrData_DI,
    input  logic                 RdEn_SI,
    input  logic [ADDR_BITW-1:0] RdAddr_DI,
    output logic [DATA_BITW-1:0] RdData_DO
);
    logic [DATA_BITW-1:0] mem [NUM_ENTRIES];

    always_ff @(posedge Clk_CI) begin
        if (WrEn_SI) mem[WrAddr_DI] <= WrData_DI;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) RdData_DO <= '0;
        else if (RdEn_SI) RdData_DO <= mem[RdAddr_DI];
    end
endmodule

// File: rtl/bram_logger_mc.sv
// bram_logger_mc: multi-channel timestamped event logger into on-chip RAM
// Clk_CI/Rst_RI: clock, async active-high reset; bus: event sources and read port
// LogEn_SI/Mode_SI/Clear_SI: global enable, 0 stop-when-full / 1 ring, start clear
// Ready_SO/Full_SO/NearlyFull_SO/Wrapped_SO/EntryCnt_DO/WrPtr_DO/DropCnt_DO: status
module bram_logger_mc
    import bram_logger_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int LOG_DATA_BITW   = 32,
    parameter int NUM_LOG_ENTRIES = 1024,
    parameter int TIMESTAMP_BITW  = 32,
    parameter int FULL_MARGIN     = 64,
    parameter int DROP_CNT_BITW   = 16,
    localparam int ADDR_BITW      = clog2(NUM_LOG_ENTRIES)
) (
    input  logic                              Clk_CI,
    input  logic                              Rst_RI,
    bram_logger_mc_if.slave                   bus,
    input  logic                              LogEn_SI,
    input  logic                              Mode_SI,
    input  logic                              Clear_SI,
    output logic                              Ready_SO,
    output logic                              Full_SO,
    output logic                              NearlyFull_SO,
    output logic                              Wrapped_SO,
    output logic [ADDR_BITW:0]                EntryCnt_DO,
    output logic [ADDR_BITW-1:0]              WrPtr_DO,
    output logic [NUM_CHANNELS*DROP_CNT_BITW-1:0] DropCnt_DO
);
    localparam int CW       = chan_bitw(NUM_CHANNELS);
    localparam int EW       = entry_bitw(TIMESTAMP_BITW, CW, LOG_DATA_BITW);
    localparam int CNT_BITW = ADDR_BITW + 1;

    state_t                    state_q, state_d;
    logic [TIMESTAMP_BITW-1:0] ts_q;
    logic [CW-1:0]             rr_q, gnt_idx, k;
    logic [ADDR_BITW-1:0]      wr_ptr_q;
    logic [ADDR_BITW:0]        cnt_q;
    logic                      wrapped_q, gnt_vld, clear_go, wr_en, last_idx;
    logic [NUM_CHANNELS-1:0]   slot_vld;
    logic [LOG_DATA_BITW-1:0]  slot_data [NUM_CHANNELS];
    logic [TIMESTAMP_BITW-1:0] slot_ts [NUM_CHANNELS];
    logic [EW-1:0]             wr_data;

    assign clear_go = Clear_SI && state_q != CLEARING;
    assign last_idx = wr_ptr_q == '1;
    // A clear on the same edge wins over the grant; CLEARING reuses the write pointer as sweep index.
    assign wr_en    = (gnt_vld && !clear_go) || state_q == CLEARING;
    assign wr_data  = state_q == CLEARING ? '0 :
                      EW'(pack_entry(MAX_BITW'(slot_ts[gnt_idx]), MAX_BITW'(gnt_idx),
                                     MAX_BITW'(slot_data[gnt_idx]), TIMESTAMP_BITW, CW));

    // Round-robin: first valid slot after the last granted channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        k       = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            k = CW'((int'(rr_q) + i) % NUM_CHANNELS);
            if (!gnt_vld && slot_vld[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = k;
            end
        end
        gnt_vld = gnt_vld && state_q == READY;
    end

    always_comb begin
        state_d = clear_go                               ? CLEARING :
                  (state_q == CLEARING && last_idx)      ? READY    :
                  (gnt_vld && last_idx && !Mode_SI)      ? FULL     : state_q;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q   <= READY;
            ts_q      <= '0;
            rr_q      <= CW'(NUM_CHANNELS - 1);
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 1'b1;
            if (clear_go) begin
                wr_ptr_q  <= '0;
                cnt_q     <= '0;
                wrapped_q <= 1'b0;
            end else if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (state_q == READY) begin
                    rr_q <= gnt_idx;
                    if (cnt_q != CNT_BITW'(NUM_LOG_ENTRIES)) cnt_q <= cnt_q + 1'b1;
                    if (last_idx && Mode_SI) wrapped_q <= 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic                      gnt_c, trig_c, acc_c, drop_c, vld_q;
        logic [LOG_DATA_BITW-1:0]  data_q;
        logic [TIMESTAMP_BITW-1:0] ts_c_q;
        logic [DROP_CNT_BITW-1:0]  drop_q;
        assign gnt_c  = gnt_vld && gnt_idx == CW'(c);
        assign trig_c = bus.LogTrigger_SI[c] && bus.ChanEn_SI[c] && LogEn_SI;
        assign acc_c  = trig_c && state_q == READY && (!vld_q || gnt_c);
        assign drop_c = trig_c && (state_q == FULL || (state_q == READY && vld_q && !gnt_c));
        // Outside READY the slot empties silently (FULL discards, CLEARING holds nothing).
        always_ff @(posedge Clk_CI or posedge Rst_RI) begin
            if (Rst_RI) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                ts_c_q <= '0;
                drop_q <= '0;
            end else if (clear_go) begin
                vld_q  <= 1'b0;
                drop_q <= '0;
            end else begin
                vld_q <= acc_c || (vld_q && !gnt_c && state_q == READY);
                if (acc_c) begin
                    data_q <= bus.LogData_DI[c*LOG_DATA_BITW +: LOG_DATA_BITW];
                    ts_c_q <= ts_q;
                end
                if (drop_c && drop_q != '1) drop_q <= drop_q + 1'b1;
            end
        end
        assign slot_vld[c]  = vld_q;
        assign slot_data[c] = data_q;
        assign slot_ts[c]   = ts_c_q;
        assign DropCnt_DO[c*DROP_CNT_BITW +: DROP_CNT_BITW] = drop_q;
    end

    sdp_bram_array #(.DATA_BITW(EW), .NUM_ENTRIES(NUM_LOG_ENTRIES)) u_ram (
        .Clk_CI    (Clk_CI),
        .Rst_RI    (Rst_RI),
        .WrEn_SI   (wr_en),
        .WrAddr_DI (wr_ptr_q),
        .WrData_DI (wr_data),
        .RdEn_SI   (bus.RdEn_SI),
        .RdAddr_DI (bus.RdAddr_DI),
        .RdData_DO (bus.RdData_DO)
    );

    assign Ready_SO      = state_q == READY;
    assign Full_SO       = state_q == FULL;
    assign NearlyFull_SO = !Mode_SI && cnt_q >= CNT_BITW'(NUM_LOG_ENTRIES - FULL_MARGIN);
    assign Wrapped_SO    = wrapped_q;
    assign EntryCnt_DO   = cnt_q;
    assign WrPtr_DO      = wr_ptr_q;
endmodule
